// File: rtl/bpred_pkg.sv
// Shared branch-prediction types and helpers (PHT, BTB, future tournament chooser).
package bpred_pkg;

  localparam int PHT_IDX_W = 11;
  localparam int PHT_CTR_W = 2;

  typedef logic [PHT_IDX_W-1:0] idx_t;
  typedef logic [PHT_CTR_W-1:0] ctr_t;

  // Weakly-not-taken: one below the taken threshold.
  localparam ctr_t WEAK_NT = ctr_t'((1 << (PHT_CTR_W - 1)) - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } pht_state_e;

  // XOR of successive w-bit slices of pc[31:2]; the last partial slice is
  // implicitly zero-padded. Result is in the low w bits.
  function automatic logic [31:0] pc_fold(input logic [31:0] pc, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 30; i++) begin
      r[i % w] = r[i % w] ^ pc[i + 2];
    end
    return r;
  endfunction

  // Saturating counter steps for counters up to 4 bits wide.
  function automatic logic [3:0] sat_inc(input logic [3:0] c, input int w);
    logic [3:0] mx;
    mx = 4'((1 << w) - 1);
    return (c == mx) ? c : c + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] c);
    return (c == 4'd0) ? c : c - 4'd1;
  endfunction

endpackage

// File: rtl/pht_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// 1-cycle latency (read-first on address collision). No reset; the owner
// clears it by sweeping.
module pht_sdp_ram #(
  parameter int AW = 11,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pht_predictor.sv
// Pattern history table direction predictor.
// Build option BPRED_GHIST_EN: gshare indexing with a speculative global
// history register and mispredict repair. Without it the predictor is bimodal
// and pred_ghist is tied to zero.
//
// state  | meaning
// S_INIT | sweeping the table, writing WEAK_NT to one entry per cycle
// S_RUN  | ready; lookups and updates accepted
module pht_predictor
  import bpred_pkg::*;
#(
  parameter int IDX_W = PHT_IDX_W,
  parameter int CTR_W = PHT_CTR_W,
  parameter int GHR_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_counter,
  output logic [GHR_W-1:0] pred_ghist,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [CTR_W-1:0] upd_counter,
  input  logic             upd_taken,
  input  logic [GHR_W-1:0] upd_ghist,
  input  logic             upd_mispredict
);

  localparam logic [CTR_W-1:0] WEAK_VAL = CTR_W'((1 << (CTR_W - 1)) - 1);

  pht_state_e       state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             running, req_acc, upd_acc;
  logic [IDX_W-1:0] r_fold, w_fold, ridx, widx;
  logic [3:0]       upd_step;
  logic [CTR_W-1:0] upd_new;
  logic             pv_q, byp_hit_q;
  logic [CTR_W-1:0] byp_val_q, ram_rdata, ctr_sel;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [CTR_W-1:0] ram_wdata;

  assign running = (state_q == S_RUN);
  assign ready   = running;
  assign req_acc = req_valid & running;
  assign upd_acc = upd_valid & running;

  assign r_fold   = IDX_W'(pc_fold(req_pc, IDX_W));
  assign w_fold   = IDX_W'(pc_fold(upd_pc, IDX_W));
  assign upd_step = upd_taken ? sat_inc(4'(upd_counter), CTR_W) : sat_dec(4'(upd_counter));
  assign upd_new  = CTR_W'(upd_step);

`ifdef BPRED_GHIST_EN
  logic [GHR_W-1:0] ghr_q, ghr_d, ghist_q;

  assign ridx       = r_fold ^ IDX_W'(ghr_q);
  assign widx       = w_fold ^ IDX_W'(upd_ghist);
  assign pred_ghist = ghist_q;

  // Speculative shift on each prediction; a mispredict repair wins.
  always_comb begin
    ghr_d = ghr_q;
    if (pv_q) ghr_d = GHR_W'({ghr_q, pred_taken});
    if (upd_acc && upd_mispredict) ghr_d = GHR_W'({upd_ghist, upd_taken});
  end

  // History register and per-prediction snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q   <= '0;
      ghist_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (req_acc) ghist_q <= ghr_q;
    end
  end
`else
  logic unused_ghist;

  assign ridx         = r_fold;
  assign widx         = w_fold;
  assign pred_ghist   = '0;
  assign unused_ghist = ^{upd_ghist, upd_mispredict};
`endif

  // Init sweep walks every entry once, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_INIT: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  // FSM state and sweep address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign ram_we    = ~running | upd_acc;
  assign ram_waddr = running ? widx : addr_q;
  assign ram_wdata = running ? upd_new : WEAK_VAL;

  pht_sdp_ram #(.AW(IDX_W), .DW(CTR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (req_acc),
    .raddr_i (ridx),
    .rdata_o (ram_rdata)
  );

  // Lookup pipeline; the RAM reads old data on a same-cycle collision, so the
  // freshly computed counter is captured for a bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q      <= 1'b0;
      byp_hit_q <= 1'b0;
      byp_val_q <= '0;
    end else begin
      pv_q      <= req_acc;
      byp_hit_q <= req_acc & upd_acc & (widx == ridx);
      byp_val_q <= upd_new;
    end
  end

  assign ctr_sel      = byp_hit_q ? byp_val_q : ram_rdata;
  assign pred_valid   = pv_q;
  assign pred_counter = pv_q ? ctr_sel : '0;
  assign pred_taken   = pred_counter[CTR_W-1];

endmodule

// File: tb/tb_pht_predictor.sv
// Directed bench for pht_predictor with default parameters.
module tb_pht_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_counter;
  logic [10:0] pred_ghist;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_counter;
  logic        upd_taken;
  logic [10:0] upd_ghist;
  logic        upd_mispredict;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pht_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_counter   (pred_counter),
    .pred_ghist     (pred_ghist),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_counter    (upd_counter),
    .upd_taken      (upd_taken),
    .upd_ghist      (upd_ghist),
    .upd_mispredict (upd_mispredict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic lookup(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [1:0] ctr, input logic tkn,
                        input logic [10:0] gh, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_counter    = ctr;
    upd_taken      = tkn;
    upd_ghist      = gh;
    upd_mispredict = misp;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    bit saw_pv, saw_rdy;
    reset = 1'b1; req_valid = 1'b0; req_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_counter = '0; upd_taken = 1'b0;
    upd_ghist = '0; upd_mispredict = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_pred_valid", 32'(pred_valid), 32'h0);
    chk("rst_pred_counter", 32'(pred_counter), 32'h0);
    chk("rst_pred_taken", 32'(pred_taken), 32'h0);
    chk("rst_pred_ghist", 32'(pred_ghist), 32'h0);

    // Sweep: 2048 edges with a request held high that must be dropped.
    reset = 1'b0; req_valid = 1'b1; req_pc = 32'h1234_5678;
    saw_pv = 1'b0; saw_rdy = 1'b0;
    for (int i = 1; i <= 2047; i++) begin
      tick();
      if (pred_valid) saw_pv = 1'b1;
      if (ready) saw_rdy = 1'b1;
    end
    chk("sweep_ready_early", 32'(saw_rdy), 32'h0);
    chk("sweep_req_dropped", 32'(saw_pv), 32'h0);
    tick();
    req_valid = 1'b0;
    chk("sweep_ready_2048", 32'(ready), 32'h1);
    chk("sweep_last_dropped", 32'(pred_valid), 32'h0);

    lookup(32'h00AB_CDE0);
    chk("first_valid", 32'(pred_valid), 32'h1);
    chk("first_counter", 32'(pred_counter), 32'h1);
    chk("first_taken", 32'(pred_taken), 32'h0);
    tick();
    chk("valid_drops", 32'(pred_valid), 32'h0);

`ifndef BPRED_GHIST_EN
    update(32'h1000, 2'b01, 1'b1, '0, 1'b0);
    update(32'h1000, 2'b10, 1'b1, '0, 1'b0);
    update(32'h1000, 2'b11, 1'b1, '0, 1'b0);
    lookup(32'h1000);
    chk("train_taken_ctr", 32'(pred_counter), 32'h3);
    chk("train_taken_dir", 32'(pred_taken), 32'h1);
    chk("train_ghist0", 32'(pred_ghist), 32'h0);
    update(32'h1000, 2'b11, 1'b0, '0, 1'b0);
    lookup(32'h1000);
    chk("train_nt_ctr", 32'(pred_counter), 32'h2);
    update(32'h1000, 2'b11, 1'b1, '0, 1'b0);
    lookup(32'h1000);
    chk("sat_high", 32'(pred_counter), 32'h3);
    update(32'h1000, 2'b00, 1'b0, '0, 1'b0);
    lookup(32'h1000);
    chk("sat_low", 32'(pred_counter), 32'h0);

    // 0x3004 folds to 0x401 ^ 0x001 = 0x400, same as 0x1000.
    update(32'h3004, 2'b00, 1'b1, '0, 1'b0);
    lookup(32'h1000);
    chk("alias_ctr", 32'(pred_counter), 32'h1);

    // Same-cycle update and lookup of one entry.
    upd_valid = 1'b1; upd_pc = 32'h2000; upd_counter = 2'b01; upd_taken = 1'b1;
    req_valid = 1'b1; req_pc = 32'h2000;
    tick();
    upd_valid = 1'b0; req_valid = 1'b0;
    chk("bypass_valid", 32'(pred_valid), 32'h1);
    chk("bypass_ctr", 32'(pred_counter), 32'h2);
    lookup(32'h2000);
    chk("bypass_stored", 32'(pred_counter), 32'h2);
    chk("bimodal_ghist0", 32'(pred_ghist), 32'h0);
`endif

    // Restart mid-sweep at address 500.
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (500) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_ready", 32'(ready), 32'h0);
    saw_rdy = 1'b0;
    for (int i = 1; i <= 2047; i++) begin
      tick();
      if (ready) saw_rdy = 1'b1;
    end
    chk("midrst_ready_early", 32'(saw_rdy), 32'h0);
    tick();
    chk("midrst_ready_2048", 32'(ready), 32'h1);
    for (int i = 0; i < 500; i += 83) begin
      lookup(32'(i) << 2);
      chk($sformatf("readback_%0d", i), 32'(pred_counter), 32'h1);
    end
    lookup(32'h2000);
    chk("readback_2000", 32'(pred_counter), 32'h1);
    lookup(32'h1000);
    chk("readback_1000", 32'(pred_counter), 32'h1);

`ifdef BPRED_GHIST_EN
    // GHR is 0 here (all predictions so far not taken). Train index 0x400.
    tick();
    update(32'h1000, 2'b01, 1'b1, '0, 1'b0);
    lookup(32'h1000);
    chk("gh_a_taken", 32'(pred_taken), 32'h1);
    chk("gh_a_ghist", 32'(pred_ghist), 32'h0);
    tick();
    lookup(32'h1004);
    chk("gh_b_taken", 32'(pred_taken), 32'h1);
    chk("gh_b_ghist", 32'(pred_ghist), 32'h1);
    tick();
    lookup(32'h100C);
    chk("gh_c_taken", 32'(pred_taken), 32'h1);
    chk("gh_c_ghist", 32'(pred_ghist), 32'h3);
    tick();
    lookup(32'h101C);
    chk("gh_d_taken", 32'(pred_taken), 32'h1);
    chk("gh_d_ghist", 32'(pred_ghist), 32'h7);
    // Repair in the same cycle as the pending speculative shift.
    update(32'h9000, 2'b01, 1'b0, '0, 1'b1);
    lookup(32'h5000);
    chk("gh_repair", 32'(pred_ghist), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pht_predictor.md
# pht_predictor

Parametrised branch direction predictor: a pattern history table of saturating counters indexed by a folded PC, optionally XORed with a speculative global history register. It sits in the fetch stage beside the BTB. Fetch issues one lookup per cycle, and the commit-side branch unit returns one update per cycle. After reset the block clears its own table with an init sweep, and it repairs global history on a mispredict.

## Interface
- IDX_W, 11, PHT index width; table depth is 2^IDX_W entries
- CTR_W, 2, counter width, 2..4
- GHR_W, 11, global history length, 1..IDX_W
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ready  out  1  high once the init sweep completes; lookups accepted only when high
- req_valid  in  1  lookup request
- req_pc  in  32  fetch PC
- pred_valid  out  1  prediction valid, one cycle after an accepted req
- pred_taken  out  1  MSB of the predicted counter
- pred_counter  out  CTR_W  counter value, returned to the core for the later update
- pred_ghist  out  GHR_W  GHR snapshot used to form the index
- upd_valid  in  1  update strobe
- upd_pc  in  32  branch PC
- upd_counter  in  CTR_W  counter carried from the prediction
- upd_taken  in  1  resolved direction
- upd_ghist  in  GHR_W  snapshot carried from the prediction
- upd_mispredict  in  1  direction mispredicted; triggers GHR repair

## Operation
- fold(pc): XOR of successive IDX_W-bit slices of pc[31:2]; the last slice is zero-padded.
- Read index: fold(req_pc) ^ GHR, with GHR zero-extended to IDX_W. Write index: fold(upd_pc) ^ upd_ghist.
- Counter update: saturating arithmetic. On taken, the counter increments and saturates at 2^CTR_W-1. On not-taken, it decrements and saturates at 0.
- State machine:
  - INIT: the address counter walks 0..2^IDX_W-1, writing the weakly-not-taken value (2^(CTR_W-1)-1) to one entry per cycle. req and upd inputs are ignored.
  - RUN: entered after the last entry is written. ready=1.
- Speculative history: each cycle with pred_valid=1, GHR <= {GHR[GHR_W-2:0], pred_taken}.
- Repair: when upd_valid && upd_mispredict, GHR <= {upd_ghist[GHR_W-2:0], upd_taken}. Repair takes priority over a same-cycle speculative shift.
- Write bypass: if upd_valid is high and the write index equals the read index in the same cycle as an accepted req, the prediction returns the new counter from a registered bypass, not the RAM output.
- Reset outputs: ready=0, pred_valid=0, pred_taken=0, pred_counter=0, pred_ghist=0; GHR=0; FSM in INIT at address 0.

## Timing
- Lookup latency is 1 cycle: req accepted at edge t gives pred_* valid during cycle t+1. Throughput is 1 lookup per cycle.
- An update is written at the edge following upd_valid. A read issued in any later cycle sees the new value.
- The init sweep takes exactly 2^IDX_W cycles. ready rises in the cycle after the final write.
- A req arriving while ready=0 is dropped: no pred_valid and no GHR change.
- Reset asserted mid-sweep or mid-run restarts INIT from address 0 and clears GHR. A pred_valid already pending is cancelled.
- pred_ghist is the GHR value before the shift caused by this prediction.

## Configuration
- Macro: BPRED_GHIST_EN.
- Defined: gshare indexing, speculative GHR and repair path, all as described above.
- Undefined: pure bimodal predictor.
  - Index is fold(pc) only; no GHR is instantiated.
  - pred_ghist is tied to 0; upd_ghist and upd_mispredict are ignored.
  - Lookup latency and init sweep are unchanged.

## Structure
- Package bpred_pkg holds:
  - the ctr_t and idx_t typedefs;
  - the WEAK_NT constant;
  - the pc_fold(), sat_inc() and sat_dec() functions, shared with the BTB and a future tournament chooser.
- Sub-module pht_sdp_ram: a generic simple dual-port synchronous RAM with a write port and a read port of 1-cycle latency. It holds no reset logic; clearing is done by the init sweep.

## Test plan
- Reset, then wait: ready stays low for 2048 cycles and rises at cycle 2049. A random-PC lookup then returns pred_counter=2'b01, pred_taken=0.
- Update PC 0x1000 taken three times with counters 01, 10, 11 → a lookup of 0x1000 returns 11. One not-taken update with 11 → returns 10.
- Same-cycle update of 0x2000 (counter 01, taken) and lookup of 0x2000 → pred_counter=10 via the bypass.
- With BPRED_GHIST_EN: predict taken on 3 lookups → GHR=3'b111 in the low bits. Then update with upd_mispredict=1, upd_ghist=0, upd_taken=0 concurrently with a pred_valid → GHR=0.
- Assert reset at sweep address 500 → ready stays low for a full 2048 further cycles. Entries 0..499 read back as WEAK_NT after ready rises.
- Without BPRED_GHIST_EN: pred_ghist=0 always. Two PCs with equal fold values alias to the same counter.
